ahb_lite_master: RTL

- Synthesizable AHB-Lite initiator. Drives the slave bus (HSEL/HADDR/HTRANS/HWDATA...) from a simple valid/ready command stream and returns one response per command.
- Pipelines address and data phases: the next command's address phase overlaps the current data phase.
- Handles HREADY wait states and the two-cycle HRESP ERROR response.
- Used as the RTL stimulus source in front of the ahb3liten slave and as a reusable bus initiator.

---
 rtl/ahb_lite_master.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into pipelined AHB-Lite transfers, one response per command.
// Latency: command accept -> rsp_valid is 3 cycles with HREADY=1 (accept, address phase, data phase); each wait state adds one.
// Backpressure: cmd_ready follows HREADY, is low while an ERROR response is in progress and while a held address phase blocks the pipe.
//
// Ports:
//   HCLK, HRESETn               bus clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_write, cmd_addr, cmd_size, cmd_wdata, cmd_seq carry the command
//   rsp_valid/rsp_rdata/rsp_err one-cycle in-order response per command (rdata is 0 for writes)
//   HSEL..HWDATA                AHB-Lite initiator outputs; HRDATA, HREADY, HRESP slave inputs
//
// Optional macro AHB_MST_INCR_BURST_EN: chained cmd_seq commands go out as SEQ beats of an INCR burst.
// Without it cmd_seq is ignored and every transfer is NONSEQ/SINGLE.
module ahb_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    // command stream
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              cmd_seq,
    // response stream
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // AHB-Lite bus
    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    localparam logic [1:0] TR_IDLE      = 2'b00;
    localparam logic [1:0] TR_NONSEQ    = 2'b10;
    localparam logic [1:0] TR_SEQ       = 2'b11;
    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;

    // ST_BOOT keeps cmd_ready low for the first cycle after reset release.
    // ST_ERR is the second ERROR cycle: the bus is forced to IDLE and the
    // address-phase command is parked until it can be re-issued.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // address-phase stage
    logic              ap_vld_q,   ap_vld_d;
    logic [ADDR_W-1:0] ap_addr_q,  ap_addr_d;
    logic              ap_write_q, ap_write_d;
    logic [2:0]        ap_size_q,  ap_size_d;
    logic [DATA_W-1:0] ap_wdata_q, ap_wdata_d;
    logic              ap_seq_q,   ap_seq_d;
    logic [2:0]        ap_burst_q, ap_burst_d;

    // data-phase stage
    logic              dp_vld_q,   dp_vld_d;
    logic              dp_write_q, dp_write_d;
    logic [DATA_W-1:0] dp_wdata_q, dp_wdata_d;

    // registered response
    logic              rsp_vld_q,   rsp_vld_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

    logic bus_cancel;   // address phase suppressed during ERROR cycle 2
    logic ap_live;      // address phase actually presented on the bus
    logic ap_adv;       // address phase accepted by the slave this cycle
    logic dp_done;      // data phase completes this cycle
    logic err_first;    // first ERROR cycle (HRESP=1, HREADY=0)
    logic err_busy;     // any ERROR cycle in progress
    logic cmd_rdy_c;
    logic cmd_acc;
    logic cmd_chain;    // accepted command continues the burst in AP
    logic [2:0] cmd_burst;

    assign bus_cancel = (state_q == ST_ERR);
    assign ap_live    = ap_vld_q && !bus_cancel;
    assign ap_adv     = ap_live && HREADY;
    assign dp_done    = dp_vld_q && HREADY;
    assign err_first  = dp_vld_q && HRESP && !HREADY;
    assign err_busy   = bus_cancel || (dp_vld_q && HRESP);
    assign cmd_rdy_c  = (state_q != ST_BOOT) && HREADY && !err_busy
                        && (!ap_vld_q || ap_adv);
    assign cmd_acc    = cmd_valid && cmd_rdy_c;

`ifdef AHB_MST_INCR_BURST_EN
    // A command can only chain onto the beat leaving AP this very cycle;
    // if AP is empty the bus showed IDLE, which already ended the burst.
    logic [ADDR_W-1:0] beat_step;
    assign beat_step = ADDR_W'(1) << cmd_size;
    assign cmd_chain = cmd_seq && ap_adv
                       && (cmd_addr == ap_addr_q + beat_step)
                       && (cmd_size == ap_size_q)
                       && (cmd_write == ap_write_q);
    assign cmd_burst = BURST_INCR;
`else
    logic unused_cmd_seq;
    assign unused_cmd_seq = cmd_seq;
    assign cmd_chain      = 1'b0;
    assign cmd_burst      = BURST_SINGLE;
`endif

    always_comb begin
        state_d     = state_q;
        ap_vld_d    = ap_vld_q;
        ap_addr_d   = ap_addr_q;
        ap_write_d  = ap_write_q;
        ap_size_d   = ap_size_q;
        ap_wdata_d  = ap_wdata_q;
        ap_seq_d    = ap_seq_q;
        ap_burst_d  = ap_burst_q;
        dp_vld_d    = dp_vld_q;
        dp_write_d  = dp_write_q;
        dp_wdata_d  = dp_wdata_q;
        rsp_vld_d   = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (err_first) state_d = ST_ERR;
            ST_ERR:  if (HREADY)    state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase

        // A parked command comes back as NONSEQ: its burst chain is broken.
        if (bus_cancel) begin
            ap_seq_d = 1'b0;
        end

        if (cmd_acc) begin
            ap_vld_d   = 1'b1;
            ap_addr_d  = cmd_addr;
            ap_write_d = cmd_write;
            ap_size_d  = cmd_size;
            ap_wdata_d = cmd_wdata;
            ap_seq_d   = cmd_chain;
            ap_burst_d = cmd_burst;
        end else if (ap_adv) begin
            ap_vld_d   = 1'b0;
        end

        if (ap_adv) begin
            dp_vld_d   = 1'b1;
            dp_write_d = ap_write_q;
            dp_wdata_d = ap_write_q ? ap_wdata_q : '0;
        end else if (dp_done) begin
            dp_vld_d   = 1'b0;
        end

        if (dp_done) begin
            rsp_vld_d   = 1'b1;
            rsp_rdata_d = dp_write_q ? '0 : HRDATA;
            rsp_err_d   = HRESP;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_BOOT;
            ap_vld_q    <= 1'b0;
            ap_addr_q   <= '0;
            ap_write_q  <= 1'b0;
            ap_size_q   <= 3'd0;
            ap_wdata_q  <= '0;
            ap_seq_q    <= 1'b0;
            ap_burst_q  <= BURST_SINGLE;
            dp_vld_q    <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_wdata_q  <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ap_vld_q    <= ap_vld_d;
            ap_addr_q   <= ap_addr_d;
            ap_write_q  <= ap_write_d;
            ap_size_q   <= ap_size_d;
            ap_wdata_q  <= ap_wdata_d;
            ap_seq_q    <= ap_seq_d;
            ap_burst_q  <= ap_burst_d;
            dp_vld_q    <= dp_vld_d;
            dp_write_q  <= dp_write_d;
            dp_wdata_q  <= dp_wdata_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = cmd_rdy_c;
    assign rsp_valid = rsp_vld_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign HSEL   = ap_live;
    assign HTRANS = ap_live ? (ap_seq_q ? TR_SEQ : TR_NONSEQ) : TR_IDLE;
    assign HADDR  = ap_addr_q;
    assign HWRITE = ap_write_q;
    assign HSIZE  = ap_size_q;
    assign HBURST = ap_burst_q;
    assign HPROT  = 4'b0011;
    assign HWDATA = dp_wdata_q;

endmodule
